// File: rtl/vec_regfile_pkg.sv
// Shared definitions for the vector register file: size defaults, LMUL encodings,
// the group-write FSM states and the LMUL decode helper.
package vec_regfile_pkg;

    localparam int VLEN_DEF     = 512;
    localparam int NUM_REGS_DEF = 32;

    localparam logic [3:0] LMUL_1 = 4'b0001;
    localparam logic [3:0] LMUL_2 = 4'b0010;
    localparam logic [3:0] LMUL_4 = 4'b0100;
    localparam logic [3:0] LMUL_8 = 4'b1000;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

    // Returns the register count of a one-hot LMUL code; 0 flags an illegal code.
    function automatic logic [3:0] lmul_to_len(input logic [3:0] lmul);
        case (lmul)
            LMUL_1:  lmul_to_len = 4'd1;
            LMUL_2:  lmul_to_len = 4'd2;
            LMUL_4:  lmul_to_len = 4'd4;
            LMUL_8:  lmul_to_len = 4'd8;
            default: lmul_to_len = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vec_regfile_seq_if.sv
// Beat-serial group write channel between the execute/load units and the register file.
interface vec_regfile_seq_if #(
    parameter int VLEN = 512,
    parameter int AW   = 5
);
    logic            wr_start;
    logic [AW-1:0]   wr_addr;
    logic [3:0]      wr_lmul;
    logic            wr_valid;
    logic            wr_ready;
    logic [VLEN-1:0] wr_data;
    logic            wr_done;
    logic            wr_err;
    logic            busy;

    modport master (
        output wr_start, wr_addr, wr_lmul, wr_valid, wr_data,
        input  wr_ready, wr_done, wr_err, busy
    );

    modport slave (
        input  wr_start, wr_addr, wr_lmul, wr_valid, wr_data,
        output wr_ready, wr_done, wr_err, busy
    );
endinterface

// File: rtl/vec_wr_sequencer.sv
// Group write sequencer: checks a group request, then steps one register per
// accepted beat and reports completion or rejection one cycle later.
module vec_wr_sequencer
    import vec_regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_start,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_lmul,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          wr_done,
    output logic          wr_err,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_idx,
    output logic          grp_start,
    output logic [AW-1:0] grp_base,
    output logic [3:0]    grp_len
);

    wr_state_e     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [3:0]    len_q, len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [3:0]    req_len;
    logic [AW:0]   req_end;
    logic          legal;
    logic          last_beat;

    assign req_len = lmul_to_len(wr_lmul);
    assign req_end = {1'b0, wr_addr} + (AW+1)'(req_len);
    // LMUL is a power of two, so alignment reduces to masking the low address bits.
    assign legal   = (req_len != 4'd0)
                   && ((wr_addr & AW'(req_len - 4'd1)) == '0)
                   && (req_end <= (AW+1)'(NUM_REGS));

    assign last_beat = (4'({1'b0, cnt_q}) + 4'd1) == len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    if (legal) begin
                        state_d = WRITE;
                        base_d  = wr_addr;
                        len_d   = req_len;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ready  = (state_q == WRITE);
    assign busy      = (state_q == WRITE);
    assign wr_done   = done_q;
    assign wr_err    = err_q;
    assign wr_stb    = (state_q == WRITE) && wr_valid;
    assign wr_idx    = base_q + AW'(cnt_q);
    assign grp_start = (state_q == IDLE) && wr_start && legal;
    assign grp_base  = wr_addr;
    assign grp_len   = req_len;

endmodule

// File: rtl/vec_regfile_seq.sv
// Vector register file with a beat-serial group write port, pending-write
// scoreboard for operand fetch, and a dedicated mask write path for v0.
module vec_regfile_seq
    import vec_regfile_pkg::*;
#(
    parameter int VLEN     = VLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 3,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    vec_regfile_seq_if.slave       wr,
    input  logic                   mask_wr_en,
    input  logic [VLEN-1:0]        mask_wdata,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*VLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    output logic [VLEN-1:0]        v0_mask_data
);

    logic [VLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    logic          wr_stb;
    logic [AW-1:0] wr_idx;
    logic          grp_start;
    logic [AW-1:0] grp_base;
    logic [3:0]    grp_len;

    vec_wr_sequencer #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .wr_start  (wr.wr_start),
        .wr_addr   (wr.wr_addr),
        .wr_lmul   (wr.wr_lmul),
        .wr_valid  (wr.wr_valid),
        .wr_ready  (wr.wr_ready),
        .wr_done   (wr.wr_done),
        .wr_err    (wr.wr_err),
        .busy      (wr.busy),
        .wr_stb    (wr_stb),
        .wr_idx    (wr_idx),
        .grp_start (grp_start),
        .grp_base  (grp_base),
        .grp_len   (grp_len)
    );

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (grp_start && (i >= int'(grp_base)) && (i < int'(grp_base) + int'(grp_len)))
                set_mask[i] = 1'b1;
            if (wr_stb && (int'(wr_idx) == i))
                clr_mask[i] = 1'b1;
        end
    end

    // v0 only follows the mask path; group beats aimed at v0 just retire its pending bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pending <= '0;
        end else begin
            if (mask_wr_en)
                regs[0] <= mask_wdata;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (clr_mask[i])
                    regs[i] <= wr.wr_data;
            end
            pending <= (pending | set_mask) & ~clr_mask;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*VLEN +: VLEN] = regs[rd_addr[p*AW +: AW]];
            rd_busy[p]              = pending[rd_addr[p*AW +: AW]];
        end
    end

    assign v0_mask_data = regs[0];

endmodule

// File: tb/tb_vec_regfile_seq.sv
// Randomized and directed bench for vec_regfile_seq, checked every cycle against
// a queue-based model of group writes, the register contents and the scoreboard.
module tb_vec_regfile_seq;
    localparam int VLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 3;
    localparam int AW       = $clog2(NUM_REGS);

    logic                   clk;
    logic                   reset;
    logic                   mask_wr_en;
    logic [VLEN-1:0]        mask_wdata;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*VLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [VLEN-1:0]        v0_mask_data;

    int checks;
    int failures;

    logic [VLEN-1:0] mRegs [NUM_REGS];
    bit              mPend [NUM_REGS];
    bit              mOpen;
    bit              mDone;
    bit              mErr;
    int              mTargets[$];

    vec_regfile_seq_if #(.VLEN(VLEN), .AW(AW)) wrIf ();

    vec_regfile_seq #(
        .VLEN     (VLEN),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wrIf.slave),
        .mask_wr_en   (mask_wr_en),
        .mask_wdata   (mask_wdata),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .v0_mask_data (v0_mask_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] observed,
                               input logic [VLEN-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NUM_REGS; i++) begin
            mRegs[i] = '0;
            mPend[i] = 1'b0;
        end
        mOpen = 1'b0;
        mDone = 1'b0;
        mErr  = 1'b0;
        mTargets.delete();
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic modelUpdate();
        int len;
        int t;
        bit newDone;
        bit newErr;
        if (!reset) begin
            modelClear();
            return;
        end
        newDone = 1'b0;
        newErr  = 1'b0;
        if (mOpen) begin
            if (wrIf.wr_valid) begin
                t = mTargets.pop_front();
                if (t != 0) mRegs[t] = wrIf.wr_data;
                mPend[t] = 1'b0;
                if (mTargets.size() == 0) begin
                    mOpen   = 1'b0;
                    newDone = 1'b1;
                end
            end
        end else if (wrIf.wr_start) begin
            case (wrIf.wr_lmul)
                4'b0001: len = 1;
                4'b0010: len = 2;
                4'b0100: len = 4;
                4'b1000: len = 8;
                default: len = 0;
            endcase
            if (len != 0 && (int'(wrIf.wr_addr) % len) == 0 && int'(wrIf.wr_addr) + len <= NUM_REGS) begin
                for (int k = 0; k < len; k++) begin
                    mTargets.push_back(int'(wrIf.wr_addr) + k);
                    mPend[int'(wrIf.wr_addr) + k] = 1'b1;
                end
                mOpen = 1'b1;
            end else begin
                newErr = 1'b1;
            end
        end
        if (mask_wr_en) mRegs[0] = mask_wdata;
        mDone = newDone;
        mErr  = newErr;
    endtask

    task automatic compareAll();
        int a;
        checkOutput("wr_ready", VLEN'(wrIf.wr_ready), VLEN'(mOpen));
        checkOutput("busy", VLEN'(wrIf.busy), VLEN'(mOpen));
        checkOutput("wr_done", VLEN'(wrIf.wr_done), VLEN'(mDone));
        checkOutput("wr_err", VLEN'(wrIf.wr_err), VLEN'(mErr));
        checkOutput("v0_mask_data", v0_mask_data, mRegs[0]);
        for (int p = 0; p < NUM_RD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            checkOutput($sformatf("rd_data[%0d]@v%0d", p, a), rd_data[p*VLEN +: VLEN], mRegs[a]);
            checkOutput($sformatf("rd_busy[%0d]@v%0d", p, a), VLEN'(rd_busy[p]), VLEN'(mPend[a]));
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic setReads(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic applyStimulus(input logic start, input int addr, input logic [3:0] lmul,
                                 input logic valid, input logic [VLEN-1:0] data,
                                 input logic mwe, input logic [VLEN-1:0] mdata);
        wrIf.wr_start = start;
        wrIf.wr_addr  = AW'(addr);
        wrIf.wr_lmul  = lmul;
        wrIf.wr_valid = valid;
        wrIf.wr_data  = data;
        mask_wr_en    = mwe;
        mask_wdata    = mdata;
        stepCycle();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 4'b0000, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic beat(input logic [VLEN-1:0] data);
        applyStimulus(1'b0, 0, 4'b0000, 1'b1, data, 1'b0, '0);
    endtask

    task automatic asyncReset(input int cycles);
        reset = 1'b0;
        modelClear();
        for (int i = 0; i < cycles; i++) idleCycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] rl;
        int         ra;
        int         r;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        setReads(0, 5, 31);
        wrIf.wr_start = 1'b0;
        wrIf.wr_addr  = '0;
        wrIf.wr_lmul  = '0;
        wrIf.wr_valid = 1'b0;
        wrIf.wr_data  = '0;
        mask_wr_en    = 1'b0;
        mask_wdata    = '0;
        modelClear();

        // Reset state
        #1;
        idleCycle();
        idleCycle();
        checkOutput("reset_wr_ready", VLEN'(wrIf.wr_ready), '0);
        checkOutput("reset_rd_data5", rd_data[VLEN +: VLEN], '0);
        reset = 1'b1;
        idleCycle();

        // Group of four at v8
        setReads(8, 9, 11);
        applyStimulus(1'b1, 8, 4'b0100, 1'b0, '0, 1'b0, '0);
        beat(64'hA1);
        beat(64'hA2);
        beat(64'hA3);
        beat(64'hA4);
        checkOutput("grp8_done", VLEN'(wrIf.wr_done), VLEN'(1));
        checkOutput("grp8_busy_low", VLEN'(wrIf.busy), '0);
        idleCycle();
        checkOutput("v8", rd_data[0 +: VLEN], 64'hA1);
        checkOutput("v11", rd_data[2*VLEN +: VLEN], 64'hA4);

        // Rejected requests
        applyStimulus(1'b1, 6, 4'b0100, 1'b0, '0, 1'b0, '0);
        checkOutput("err_misaligned", VLEN'(wrIf.wr_err), VLEN'(1));
        applyStimulus(1'b1, 28, 4'b1000, 1'b0, '0, 1'b0, '0);
        checkOutput("err_overflow", VLEN'(wrIf.wr_err), VLEN'(1));
        applyStimulus(1'b1, 8, 4'b0011, 1'b0, '0, 1'b0, '0);
        checkOutput("err_not_onehot", VLEN'(wrIf.wr_err), VLEN'(1));
        checkOutput("err_busy_low", VLEN'(wrIf.busy), '0);
        idleCycle();

        // Stalled group at v16 with scoreboard probes
        setReads(17, 16, 8);
        applyStimulus(1'b1, 16, 4'b0010, 1'b0, '0, 1'b0, '0);
        beat(64'hB0);
        idleCycle();
        checkOutput("stall_busy17", VLEN'(rd_busy[0]), VLEN'(1));
        checkOutput("stall_busy16", VLEN'(rd_busy[1]), '0);
        idleCycle();
        applyStimulus(1'b1, 0, 4'b0001, 1'b0, '0, 1'b0, '0);
        beat(64'hB1);
        idleCycle();
        checkOutput("after_busy17", VLEN'(rd_busy[0]), '0);

        // v0 protection and concurrent mask write
        setReads(0, 1, 8);
        applyStimulus(1'b0, 0, 4'b0000, 1'b0, '0, 1'b1, 64'h5A);
        applyStimulus(1'b1, 0, 4'b0010, 1'b0, '0, 1'b0, '0);
        beat(64'hFF);
        beat(64'hEE);
        idleCycle();
        checkOutput("v0_protected", v0_mask_data, 64'h5A);
        checkOutput("v1_written", rd_data[VLEN +: VLEN], 64'hEE);
        applyStimulus(1'b1, 8, 4'b0100, 1'b0, '0, 1'b0, '0);
        beat(64'hC0);
        applyStimulus(1'b0, 0, 4'b0000, 1'b1, 64'hC1, 1'b1, 64'h77);
        beat(64'hC2);
        beat(64'hC3);
        idleCycle();
        checkOutput("v0_mask_during_grp", v0_mask_data, 64'h77);

        // Reset in the middle of an eight-register group
        setReads(24, 25, 26);
        applyStimulus(1'b1, 24, 4'b1000, 1'b0, '0, 1'b0, '0);
        beat(64'hD0);
        beat(64'hD1);
        asyncReset(2);
        checkOutput("midreset_v24", rd_data[0 +: VLEN], '0);
        idleCycle();
        applyStimulus(1'b1, 24, 4'b1000, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 8; i++) beat(VLEN'(64'hE0 + i));
        idleCycle();
        checkOutput("regrp_v25", rd_data[VLEN +: VLEN], 64'hE1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            setReads($urandom_range(0, NUM_REGS-1), $urandom_range(0, NUM_REGS-1),
                     mTargets.size() > 0 ? mTargets[0] : $urandom_range(0, NUM_REGS-1));
            r = $urandom_range(0, 9);
            rl = (r < 4) ? 4'(1 << r) : 4'($urandom_range(0, 15));
            ra = $urandom_range(0, NUM_REGS-1);
            if ($urandom_range(0, 1) == 1 && rl != 4'b0000) ra = ra & ~(int'(rl) - 1);
            if ($urandom_range(0, 199) == 0) begin
                asyncReset(1);
            end else begin
                applyStimulus($urandom_range(0, 2) == 0, ra, rl,
                              $urandom_range(0, 9) < 7, {$urandom, $urandom},
                              $urandom_range(0, 9) == 0, {$urandom, $urandom});
            end
        end
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
